// File: rtl/dec_pkg.sv
// Shared types and limits for the strobe decoder.
package dec_pkg;

  typedef enum logic {
    DEC_IDLE = 1'b0,
    DEC_HOLD = 1'b1
  } dec_state_t;

  localparam int HIT_CNT_W = 16;
  localparam int HOLD_MAX  = 255;

endpackage

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decoder; optionally maps code 0 to all-zero.
module onehot_dec #(
  parameter int IN_W         = 3,
  parameter int ZERO_IS_NULL = 1
) (
  input  logic [IN_W-1:0]      code,
  output logic [(2**IN_W)-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (!(ZERO_IS_NULL != 0 && code == '0)) onehot[code] = 1'b1;
  end

endmodule

// File: rtl/dec_strobe_gen.sv
// Registered one-hot strobe generator: each accepted code drives a strobe for HOLD cycles.
// Optional hit counter (hit_count/cnt_clr ports) enabled by defining DEC_STROBE_CNT_EN.
module dec_strobe_gen
  import dec_pkg::*;
#(
  parameter int IN_W         = 3,
  parameter int HOLD         = 4,
  parameter int ZERO_IS_NULL = 1,
  localparam int OUT_W       = 2**IN_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef DEC_STROBE_CNT_EN
  input  logic                 cnt_clr,
  output logic [HIT_CNT_W-1:0] hit_count,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in_code,
  output logic [OUT_W-1:0]     out_onehot,
  output logic                 out_valid,
  output logic                 busy
);

  localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD - 1);

  if (HOLD < 1 || HOLD > HOLD_MAX) begin : g_bad_hold
    $error("dec_strobe_gen: HOLD must be in 1..255");
  end

  dec_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] oh_q, oh_d;
  logic [OUT_W-1:0] dec;
  logic             accept;

  onehot_dec #(.IN_W(IN_W), .ZERO_IS_NULL(ZERO_IS_NULL)) u_dec (
    .code   (in_code),
    .onehot (dec)
  );

  assign out_valid  = (state_q == DEC_HOLD);
  assign busy       = out_valid;
  assign out_onehot = oh_q;
  assign in_ready   = !out_valid || (cnt_q == '0);
  assign accept     = in_valid && in_ready;

  // A reload at cnt==0 chains the next strobe with no idle gap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    oh_d    = oh_q;
    if (accept) begin
      state_d = DEC_HOLD;
      cnt_d   = CNT_LOAD;
      oh_d    = dec;
    end else if (state_q == DEC_HOLD) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        state_d = DEC_IDLE;
        oh_d    = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DEC_IDLE;
      cnt_q   <= '0;
      oh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      oh_q    <= oh_d;
    end
  end

`ifdef DEC_STROBE_CNT_EN
  logic [HIT_CNT_W-1:0] hit_q, hit_d;

  // Null-code accepts occupy the strobe window but are not counted.
  always_comb begin
    hit_d = hit_q;
    if (cnt_clr) hit_d = '0;
    else if (accept && (|dec) && (hit_q != '1)) hit_d = hit_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hit_q <= '0;
    else        hit_q <= hit_d;
  end

  assign hit_count = hit_q;
`endif

endmodule

// File: tb/tb_dec_strobe_gen.sv
// Scoreboarded bench for dec_strobe_gen: default, ZERO_IS_NULL=0 and HOLD=1 instances.
module tb_dec_strobe_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] code;
  logic       vld [3];
  logic       rdy [3];
  logic       ov  [3];
  logic       bsy [3];
  logic [7:0] oh  [3];
`ifdef DEC_STROBE_CNT_EN
  logic        clr [3];
  logic [15:0] hit [3];
`endif

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] oh;
    logic       v;
    logic       r;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  dec_strobe_gen #(.IN_W(3), .HOLD(4), .ZERO_IS_NULL(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
`ifdef DEC_STROBE_CNT_EN
    .cnt_clr(clr[0]), .hit_count(hit[0]),
`endif
    .in_valid(vld[0]), .in_ready(rdy[0]), .in_code(code),
    .out_onehot(oh[0]), .out_valid(ov[0]), .busy(bsy[0])
  );

  dec_strobe_gen #(.IN_W(3), .HOLD(4), .ZERO_IS_NULL(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef DEC_STROBE_CNT_EN
    .cnt_clr(clr[1]), .hit_count(hit[1]),
`endif
    .in_valid(vld[1]), .in_ready(rdy[1]), .in_code(code),
    .out_onehot(oh[1]), .out_valid(ov[1]), .busy(bsy[1])
  );

  dec_strobe_gen #(.IN_W(3), .HOLD(1), .ZERO_IS_NULL(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
`ifdef DEC_STROBE_CNT_EN
    .cnt_clr(clr[2]), .hit_count(hit[2]),
`endif
    .in_valid(vld[2]), .in_ready(rdy[2]), .in_code(code),
    .out_onehot(oh[2]), .out_valid(ov[2]), .busy(bsy[2])
  );

  // Each entry is the state expected during the cycle it was pushed in.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("u%0d onehot", e.id), 32'(oh[e.id]), 32'(e.oh));
      chk($sformatf("u%0d out_valid", e.id), 32'(ov[e.id]), 32'(e.v));
      chk($sformatf("u%0d busy", e.id), 32'(bsy[e.id]), 32'(e.v));
      chk($sformatf("u%0d in_ready", e.id), 32'(rdy[e.id]), 32'(e.r));
    end
  end

  task automatic step(input int id, input logic v, input logic [2:0] c,
                      input logic [7:0] eoh, input logic ev, input logic er);
    exp_t e;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) vld[i] = 1'b0;
    vld[id] = v;
    code    = c;
    e.id = id; e.oh = eoh; e.v = ev; e.r = er;
    sb.push_back(e);
  endtask

  initial begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b1;
`ifdef DEC_STROBE_CNT_EN
      clr[i] = 1'b0;
`endif
    end
    code = 3'd5;

    // Reset with a valid request pending: nothing may be captured.
    #12;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst u%0d onehot", i), 32'(oh[i]), 32'h0);
      chk($sformatf("rst u%0d out_valid", i), 32'(ov[i]), 32'h0);
      chk($sformatf("rst u%0d in_ready", i), 32'(rdy[i]), 32'h1);
    end
    @(posedge clk); #1;
    rst_n  = 1'b1;
    vld[1] = 1'b0;
    vld[2] = 1'b0;
    e.id = 0; e.oh = 8'h00; e.v = 1'b0; e.r = 1'b1;
    sb.push_back(e);
    step(0, 0, 0, 8'h20, 1, 0);
    step(0, 0, 0, 8'h20, 1, 0);
    step(0, 0, 0, 8'h20, 1, 0);
    step(0, 0, 0, 8'h20, 1, 1);
    step(0, 0, 0, 8'h00, 0, 1);

    // Single strobe, code 3
    step(0, 1, 3, 8'h00, 0, 1);
    step(0, 0, 0, 8'h08, 1, 0);
    step(0, 0, 0, 8'h08, 1, 0);
    step(0, 0, 0, 8'h08, 1, 0);
    step(0, 0, 0, 8'h08, 1, 1);
    step(0, 0, 0, 8'h00, 0, 1);

    // Back-to-back: code 5, then code 6 held valid until taken
    step(0, 1, 5, 8'h00, 0, 1);
    step(0, 1, 6, 8'h20, 1, 0);
    step(0, 1, 6, 8'h20, 1, 0);
    step(0, 1, 6, 8'h20, 1, 0);
    step(0, 1, 6, 8'h20, 1, 1);
    step(0, 0, 0, 8'h40, 1, 0);
    step(0, 0, 0, 8'h40, 1, 0);
    step(0, 0, 0, 8'h40, 1, 0);
    step(0, 0, 0, 8'h40, 1, 1);
    step(0, 0, 0, 8'h00, 0, 1);

    // Null code with ZERO_IS_NULL=1, then with ZERO_IS_NULL=0
    step(0, 1, 0, 8'h00, 0, 1);
    step(0, 0, 7, 8'h00, 1, 0);
    step(0, 0, 7, 8'h00, 1, 0);
    step(0, 0, 7, 8'h00, 1, 0);
    step(0, 0, 7, 8'h00, 1, 1);
    step(0, 0, 7, 8'h00, 0, 1);
    step(1, 1, 0, 8'h00, 0, 1);
    step(1, 0, 0, 8'h01, 1, 0);
    step(1, 0, 0, 8'h01, 1, 0);
    step(1, 0, 0, 8'h01, 1, 0);
    step(1, 0, 0, 8'h01, 1, 1);
    step(1, 0, 0, 8'h00, 0, 1);

    // Reset in cycle 2 of a code-7 strobe must clear without a clock edge
    step(0, 1, 7, 8'h00, 0, 1);
    step(0, 0, 0, 8'h80, 1, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst onehot", 32'(oh[0]), 32'h0);
    chk("midrst out_valid", 32'(ov[0]), 32'h0);
    chk("midrst busy", 32'(bsy[0]), 32'h0);
    chk("midrst in_ready", 32'(rdy[0]), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("postrst in_ready", 32'(rdy[0]), 32'h1);
    step(0, 0, 0, 8'h00, 0, 1);

    // HOLD=1 streaming
    step(2, 1, 1, 8'h00, 0, 1);
    step(2, 1, 2, 8'h02, 1, 1);
    step(2, 1, 3, 8'h04, 1, 1);
    step(2, 1, 4, 8'h08, 1, 1);
    step(2, 0, 0, 8'h10, 1, 1);
    step(2, 0, 0, 8'h00, 0, 1);

`ifdef DEC_STROBE_CNT_EN
    // Codes 1, 0, 2: the null code is not counted
    step(2, 1, 1, 8'h00, 0, 1);
    step(2, 1, 0, 8'h02, 1, 1);
    step(2, 1, 2, 8'h00, 1, 1);
    step(2, 0, 0, 8'h04, 1, 1);
    chk("hit after 1,0,2", 32'(hit[2]), 32'd2);
    @(posedge clk); #1;
    vld[2] = 1'b1; code = 3'd3; clr[2] = 1'b1;
    e.id = 2; e.oh = 8'h00; e.v = 1'b0; e.r = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    vld[2] = 1'b0; clr[2] = 1'b0;
    e.id = 2; e.oh = 8'h08; e.v = 1'b1; e.r = 1'b1;
    sb.push_back(e);
    chk("hit clr beats inc", 32'(hit[2]), 32'd0);
    // Drive the counter to saturation, then one more accept
    @(posedge clk); #1;
    vld[2] = 1'b1; code = 3'd1;
    repeat (65535) @(posedge clk);
    #1;
    chk("hit reach max", 32'(hit[2]), 32'hFFFF);
    @(posedge clk); #1;
    vld[2] = 1'b0;
    chk("hit saturate", 32'(hit[2]), 32'hFFFF);
`endif

    repeat (3) @(posedge clk);
    if (sb.size() != 0) chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dec_strobe_gen.md
Name: dec_strobe_gen

Overview:
- Parametrised, registered binary-to-one-hot decoder with a valid/ready input handshake.
- Each accepted code drives a one-hot strobe for exactly HOLD clock cycles, then the strobe clears automatically.
- Drives enable/select strobes for downstream register banks and mux selects that need a stable, glitch-free pulse of known length.
- Successor to the combinational 3-to-8 decoder; keeps its rule that code 0 decodes to all-zero.

Parameters:
- IN_W, 3: code width; OUT_W = 2**IN_W is a derived localparam, not overridable.
- HOLD, 4: strobe length in cycles; legal range 1..255; elaboration error if out of range.
- ZERO_IS_NULL, 1: 1 means code 0 decodes to all-zero output; 0 means code 0 decodes to bit 0 set.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_code is valid this cycle.
- in_ready  out  1  block can accept a code this cycle.
- in_code  in  IN_W  binary code to decode.
- out_onehot  out  OUT_W  registered one-hot strobe, all-zero when idle.
- out_valid  out  1  strobe window active.
- busy  out  1  equals out_valid; separate port for status readback.

Behaviour:
- Reset is asynchronous, active-low, and acts immediately. While rst_n = 0: out_onehot = 0, out_valid = 0, busy = 0, hold counter = 0, state = IDLE.
- in_ready is combinational: in_ready = !out_valid || (cnt == 0). It does not depend on in_valid.
- Accept occurs on a rising edge where in_valid && in_ready.
- States: IDLE (out_valid = 0) and HOLD (out_valid = 1).
- IDLE:
  - accept -> HOLD; out_onehot <= decode(in_code); cnt <= HOLD-1.
  - no accept -> stay in IDLE.
- HOLD:
  - cnt != 0 -> cnt <= cnt-1; out_onehot unchanged; in_ready = 0.
  - cnt == 0 with accept -> stay in HOLD; new decode loaded; cnt <= HOLD-1. This is back-to-back with no idle gap.
  - cnt == 0 without accept -> IDLE; out_onehot <= 0.
- Latency: strobe appears on the edge of acceptance (one register stage) and is visible the following cycle. out_valid stays high for exactly HOLD cycles per accepted code.
- Decode: bit[in_code] set, all others 0. Exception: if ZERO_IS_NULL = 1 and in_code = 0, the output is all-zero, but out_valid still asserts and the null code still occupies HOLD cycles.
- HOLD = 1: in_ready is always 1, and one code per cycle streams through.
- in_code is sampled only at accept. Changes to in_code while not accepting have no effect.
- Counter width: $clog2(HOLD) bits, minimum 1. No wrap: cnt is reloaded on accept and otherwise stops at 0.
- Reset asserted mid-hold: all outputs clear immediately. After release the block starts in IDLE with in_ready = 1.
- in_valid high during reset is ignored. The first possible accept is the first rising edge after rst_n deasserts.

Optional Feature:
- Macro: DEC_STROBE_CNT_EN.
- Defined:
  - Adds output port hit_count (16 bits).
  - hit_count increments on each accept whose decoded output is non-zero. Null-code accepts do not count.
  - Saturates at 16'hFFFF.
  - Cleared by rst_n.
  - Also adds input cnt_clr (1 bit, synchronous). cnt_clr clears hit_count and takes priority over an increment in the same cycle.
- Not defined: neither port exists, no counter logic is instantiated, and all other behaviour is identical.

Decomposition:
- Shared package dec_pkg holds:
  - state enum dec_state_t {DEC_IDLE, DEC_HOLD};
  - HIT_CNT_W = 16;
  - HOLD_MAX = 255.
- Sub-module onehot_dec: purely combinational decode of IN_W to OUT_W, parameters IN_W and ZERO_IS_NULL. Reusable elsewhere.
- The top level owns the FSM, the hold counter, the output register and the optional hit counter.

Test Plan:
- Reset: with rst_n = 0, drive in_valid = 1, in_code = 5. Required: out_onehot = 0, out_valid = 0, in_ready = 1. Nothing is accepted until the first edge after release.
- Single strobe (IN_W = 3, HOLD = 4), accept code 3:
  - out_onehot = 8'h08 and out_valid = 1 for exactly 4 cycles, then 8'h00;
  - in_ready = 0 for the first 3 of those cycles.
- Back-to-back, code 5 then code 6 held valid:
  - 8'h20 for 4 cycles, then 8'h40 for 4 cycles;
  - out_valid never drops between them.
- Null code 0 with ZERO_IS_NULL = 1:
  - out_valid = 1 for 4 cycles with out_onehot = 8'h00;
  - re-run with ZERO_IS_NULL = 0: out_onehot = 8'h01.
- Reset mid-hold: assert rst_n = 0 in cycle 2 of a code-7 strobe. Required: out_onehot = 0 immediately, without waiting for a clock edge; after release in_ready = 1.
- HOLD = 1 streaming codes 1, 2, 3, 4 on consecutive cycles: out_onehot = 02, 04, 08, 10 on consecutive cycles, with in_ready held at 1.
- With DEC_STROBE_CNT_EN defined:
  - after codes 1, 0, 2, hit_count = 2;
  - pulse cnt_clr together with an accept of code 3: hit_count = 0;
  - force the count to 16'hFFFF, then accept code 1: hit_count stays at 16'hFFFF.
